// File: rtl/fc_pkg.sv
// Shared types and helpers for the fully connected layer blocks.
package fc_pkg;

  localparam int DATA_W = 16;
  localparam int Q_FRAC = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_READ,
    S_CALC,
    S_WRITE,
    S_DONE
  } state_t;

  // Clamp an 18-bit intermediate to Q8.8; MSB of the result flags a clamp.
  function automatic logic [DATA_W:0] sat16(input logic signed [DATA_W+1:0] x);
    if (x > 18'sd32767) begin
      return {1'b1, 16'h7FFF};
    end else if (x < -18'sd32768) begin
      return {1'b1, 16'h8000};
    end else begin
      return {1'b0, x[DATA_W-1:0]};
    end
  endfunction

endpackage

// File: rtl/fc_sgd_alu.sv
// Combinational SGD step: new = sat(w - floor(g*lr / 2^LR_FRAC)).
module fc_sgd_alu
  import fc_pkg::*;
#(
  parameter int LR_FRAC = 16
) (
  input  logic [DATA_W-1:0] w_i,
  input  logic [DATA_W-1:0] g_i,
  input  logic [DATA_W-1:0] lr_i,
  output logic [DATA_W-1:0] new_o,
  output logic              sat_o
);

  localparam int EW = DATA_W + 2;

  logic signed [2*DATA_W:0] prod;
  logic signed [EW-1:0]     delta;
  logic signed [EW-1:0]     diff;

  // Arithmetic shift floors toward -inf; the shifted product always fits EW bits.
  always_comb begin
    prod  = $signed({{(DATA_W+1){g_i[DATA_W-1]}}, g_i}) *
            $signed({{(DATA_W+1){1'b0}}, lr_i});
    delta = EW'(prod >>> LR_FRAC);
    diff  = $signed({{2{w_i[DATA_W-1]}}, w_i}) - delta;
    {sat_o, new_o} = sat16(diff);
  end

endmodule

// File: rtl/fc_sgd_update.sv
// Sequential SGD engine: one read-modify-write per FC parameter per gradient word.
module fc_sgd_update
  import fc_pkg::*;
#(
  parameter int INPUT_SIZE  = 120,
  parameter int OUTPUT_SIZE = 10,
  parameter int LR_FRAC     = 16,
  parameter int ADDR_W      = $clog2(OUTPUT_SIZE*(INPUT_SIZE+1))
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       lr,
  input  logic              grad_valid,
  input  logic [15:0]       grad_data,
  output logic              grad_ready,
  output logic [ADDR_W-1:0] w_addr,
  output logic              w_rd_en,
  input  logic [15:0]       w_rdata,
  output logic              w_wr_en,
  output logic [15:0]       w_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] sat_count
);

  localparam int N = OUTPUT_SIZE * (INPUT_SIZE + 1);

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   sat_cnt_q;
  logic [DATA_W-1:0]   lr_q;
  logic [DATA_W-1:0]   grad_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                rd_en_q;
  logic                wr_en_q;
  logic                busy_q;
  logic                done_q;
  logic [DATA_W-1:0]   new_d;
  logic                sat_d;

  fc_sgd_alu #(.LR_FRAC(LR_FRAC)) u_alu (
    .w_i   (w_rdata),
    .g_i   (grad_q),
    .lr_i  (lr_q),
    .new_o (new_d),
    .sat_o (sat_d)
  );

  // Operand registers carry no reset; they are always loaded before use.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && start) begin
      lr_q <= lr;
    end
    if (state_q == S_FETCH && grad_valid) begin
      grad_q <= grad_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      sat_cnt_q <= '0;
      wdata_q   <= '0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            addr_q    <= '0;
            sat_cnt_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (grad_valid) begin
            rd_en_q <= 1'b1;
            state_q <= S_READ;
          end
        end
        S_READ: begin
          rd_en_q <= 1'b0;
          state_q <= S_CALC;
        end
        S_CALC: begin
          wdata_q <= new_d;
          wr_en_q <= 1'b1;
          if (sat_d) begin
            sat_cnt_q <= sat_cnt_q + ADDR_W'(1);
          end
          state_q <= S_WRITE;
        end
        S_WRITE: begin
          wr_en_q <= 1'b0;
          if (addr_q == ADDR_W'(N - 1)) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            addr_q  <= addr_q + ADDR_W'(1);
            state_q <= S_FETCH;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign grad_ready = (state_q == S_FETCH);
  assign w_addr     = addr_q;
  assign w_rd_en    = rd_en_q;
  assign w_wr_en    = wr_en_q;
  assign w_wdata    = wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sat_count  = sat_cnt_q;

endmodule

// File: tb/tb_fc_sgd_update.sv
// Bench for fc_sgd_update on a 3x2 layer with a behavioural parameter RAM.
module tb_fc_sgd_update;

  localparam int IS = 3;
  localparam int OS = 2;
  localparam int N  = OS * (IS + 1);
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [15:0]   lr = '0;
  logic          grad_valid = 1'b0;
  logic [15:0]   grad_data = '0;
  logic          grad_ready;
  logic [AW-1:0] w_addr;
  logic          w_rd_en;
  logic [15:0]   w_rdata = '0;
  logic          w_wr_en;
  logic [15:0]   w_wdata;
  logic          busy;
  logic          done;
  logic [AW-1:0] sat_count;

  always #5 clk = ~clk;

  fc_sgd_update #(.INPUT_SIZE(IS), .OUTPUT_SIZE(OS), .LR_FRAC(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .lr         (lr),
    .grad_valid (grad_valid),
    .grad_data  (grad_data),
    .grad_ready (grad_ready),
    .w_addr     (w_addr),
    .w_rd_en    (w_rd_en),
    .w_rdata    (w_rdata),
    .w_wr_en    (w_wr_en),
    .w_wdata    (w_wdata),
    .busy       (busy),
    .done       (done),
    .sat_count  (sat_count)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [15:0]   d;
  } sb_t;

  typedef struct {
    logic [15:0] w;
    logic [15:0] g;
    logic [15:0] lr;
    logic [15:0] ew;
    logic        es;
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  int          viol = 0;
  int          wr_cnt = 0;
  int          acc_idx = 0;
  int          exp_sat = 0;
  int          valid_pct = 100;
  logic [15:0] lr_model = '0;
  logic [15:0] ram [N];
  logic [15:0] exp_ram [N];
  logic [15:0] init_ram [N];
  logic [15:0] res_ram [N];
  logic [15:0] grads [N];
  logic [15:0] gq [$];
  sb_t         sbq [$];
  sb_t         sb_e;
  logic [16:0] acc_r;
  vec_t        tv [7];
  int          lat;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [16:0] model(input logic [15:0] w, input logic [15:0] g,
                                        input logic [15:0] l);
    longint p, d, nv;
    p  = longint'($signed(g)) * longint'({48'b0, l});
    d  = p >>> 16;
    nv = longint'($signed(w)) - d;
    if (nv > 32767) return {1'b1, 16'h7FFF};
    if (nv < -32768) return {1'b1, 16'h8000};
    return {1'b0, nv[15:0]};
  endfunction

  // Parameter RAM: one-cycle registered read.
  always @(posedge clk) begin
    if (w_rd_en) w_rdata <= ram[w_addr];
    if (w_wr_en) ram[w_addr] = w_wdata;
  end

  // Gradient source with optional random gaps.
  initial forever begin
    @(negedge clk);
    if (gq.size() > 0 && $urandom_range(0, 99) < valid_pct) begin
      grad_valid = 1'b1;
      grad_data  = gq[0];
    end else begin
      grad_valid = 1'b0;
      grad_data  = 16'($urandom);
    end
  end

  // Accepted gradient -> expected write pushed to the scoreboard.
  always @(posedge clk) begin
    if (!rst && grad_valid && grad_ready && acc_idx < N) begin
      acc_r = model(exp_ram[acc_idx], grad_data, lr_model);
      sbq.push_back({AW'(acc_idx), acc_r[15:0]});
      exp_ram[acc_idx] = acc_r[15:0];
      exp_sat += int'(acc_r[16]);
      acc_idx++;
      void'(gq.pop_front());
    end
  end

  always @(negedge clk) begin
    if (w_rd_en && w_wr_en) viol++;
    if (grad_ready && (w_rd_en || w_wr_en || !busy)) viol++;
    if (w_wr_en) begin
      wr_cnt++;
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_underflow: unexpected write addr %h data %h", w_addr, w_wdata);
      end else begin
        sb_e = sbq.pop_front();
        chk("wr_addr", 32'(w_addr), 32'(sb_e.a));
        chk("wr_data", 32'(w_wdata), 32'(sb_e.d));
      end
    end
  end

  task automatic load_grads();
    gq.delete();
    for (int i = 0; i < N; i++) gq.push_back(grads[i]);
  endtask

  task automatic run_pass(input logic [15:0] lr_v, input int pct, input bit poke,
                          output int cycles);
    bit seen;
    valid_pct = pct;
    lr_model  = lr_v;
    acc_idx   = 0;
    exp_sat   = 0;
    viol      = 0;
    seen      = 1'b0;
    cycles    = 0;
    @(negedge clk);
    lr    = lr_v;
    start = 1'b1;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(posedge clk);
      #1;
      cycles++;
      start = (poke && cycles == 10);
      lr    = 16'($urandom);
      if (done) seen = 1'b1;
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd1);
    chk("sat_count", 32'(sat_count), 32'(exp_sat));
    @(posedge clk);
    #1;
    chk("done_pulse", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("protocol", 32'(viol), 32'd0);
    chk("sb_drain", 32'(sbq.size()), 32'd0);
    for (int i = 0; i < N; i++) chk("ram", 32'(ram[i]), 32'(exp_ram[i]));
  endtask

  initial begin
    tv[0] = '{16'h0100, 16'h0200, 16'h1000, 16'h00E0, 1'b0};
    tv[1] = '{16'h0000, 16'hFFFF, 16'h0001, 16'h0001, 1'b0};
    tv[2] = '{16'h8001, 16'h7FFF, 16'hFFFF, 16'h8000, 1'b1};
    tv[3] = '{16'h7FFE, 16'h8000, 16'hFFFF, 16'h7FFF, 1'b1};
    tv[4] = '{16'h1234, 16'h7FFF, 16'h0000, 16'h1234, 1'b0};
    tv[5] = '{16'h0300, 16'hFF00, 16'h8000, 16'h0380, 1'b0};
    tv[6] = '{16'h8000, 16'h0001, 16'h0001, 16'h8000, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {grad_ready, w_rd_en, w_wr_en, w_addr, w_wdata, busy, done, sat_count},
        '0);
    @(negedge clk);
    rst = 1'b0;

    // Single-parameter vectors at addr 0, remaining gradients zero
    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < N; i++) begin
        ram[i]     = (i == 0) ? tv[v].w : 16'(i * 37 + v);
        exp_ram[i] = ram[i];
        grads[i]   = (i == 0) ? tv[v].g : 16'h0000;
      end
      load_grads();
      run_pass(tv[v].lr, 100, 1'b0, lat);
      chk("vec_w", 32'(ram[0]), 32'(tv[v].ew));
      chk("vec_sat", 32'(sat_count), 32'(tv[v].es));
      chk("latency", 32'(lat), 32'(4 * N + 1));
    end

    // Random full pass, no gaps
    for (int i = 0; i < N; i++) begin
      init_ram[i] = 16'($urandom);
      grads[i]    = 16'($urandom);
      ram[i]      = init_ram[i];
      exp_ram[i]  = init_ram[i];
    end
    load_grads();
    run_pass(16'h3A5C, 100, 1'b0, lat);
    chk("latency_rand", 32'(lat), 32'(4 * N + 1));
    for (int i = 0; i < N; i++) res_ram[i] = ram[i];

    // Same pass with gaps and a start pulse while busy
    for (int i = 0; i < N; i++) begin
      ram[i]     = init_ram[i];
      exp_ram[i] = init_ram[i];
    end
    load_grads();
    run_pass(16'h3A5C, 40, 1'b1, lat);
    for (int i = 0; i < N; i++) chk("bp_same", 32'(ram[i]), 32'(res_ram[i]));

    // Reset mid-pass after three writes
    for (int i = 0; i < N; i++) begin
      ram[i]     = init_ram[i];
      exp_ram[i] = init_ram[i];
    end
    load_grads();
    valid_pct = 100;
    lr_model  = 16'h2000;
    acc_idx   = 0;
    exp_sat   = 0;
    wr_cnt    = 0;
    @(negedge clk);
    lr    = 16'h2000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 0; c < 500 && wr_cnt < 3; c++) begin
      @(posedge clk);
      #1;
    end
    chk("mid_writes", 32'(wr_cnt), 32'd3);
    rst = 1'b1;
    gq.delete();
    #1;
    chk("mid_reset_outs", {grad_ready, w_rd_en, w_wr_en, w_addr, w_wdata, busy, done, sat_count},
        '0);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_sb_drain", 32'(sbq.size()), 32'd0);
    for (int i = 0; i < N; i++) chk("mid_ram", 32'(ram[i]), 32'(exp_ram[i]));
    for (int i = 3; i < N; i++) chk("mid_untouched", 32'(ram[i]), 32'(init_ram[i]));
    @(negedge clk);
    rst = 1'b0;

    // Fresh pass restarts at addr 0
    load_grads();
    run_pass(16'h2000, 100, 1'b0, lat);
    chk("latency_rerun", 32'(lat), 32'(4 * N + 1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
